// File: rtl/accum_sched.sv
// Two-requester round-robin burst accumulator: grants one requester, sums BURST
// operands, and publishes the result and its sticky carry when the burst completes.
module accum_sched #(
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Req0Valid,
  input  logic [WIDTH-1:0] Req0Data,
  output logic             Req0Ready,
  input  logic             Req1Valid,
  input  logic [WIDTH-1:0] Req1Data,
  output logic             Req1Ready,
  input  logic             Clear,
  output logic [WIDTH-1:0] RegSum,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovf,
  output logic             Owner,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reg_sum_q, reg_sum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             owner_q, owner_d;
  logic             carry_q, carry_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic [WIDTH:0]   add_w;

  assign owner_valid = owner_q ? Req1Valid : Req0Valid;
  assign owner_data  = owner_q ? Req1Data  : Req0Data;
  assign add_w       = {1'b0, reg_sum_q} + {1'b0, owner_data};

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d   = state_q;
    reg_sum_d = reg_sum_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    owner_d   = owner_q;
    carry_d   = carry_q;
    last_d    = last_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (Req0Valid || Req1Valid) begin
          // Requester 1 wins when alone, or when both ask and 0 was served last.
          owner_d   = Req1Valid && (!Req0Valid || !last_q);
          reg_sum_d = '0;
          cnt_d     = '0;
          carry_d   = 1'b0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (owner_valid) begin
          reg_sum_d = add_w[WIDTH-1:0];
          carry_d   = carry_q | add_w[WIDTH];
          cnt_d     = cnt_q + 4'd1;
          if (cnt_q == LAST_BEAT) begin
            sum_d   = add_w[WIDTH-1:0];
            ovf_d   = carry_q | add_w[WIDTH];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort discards any beat offered this cycle and leaves published results alone.
    if (Clear) begin
      state_d   = IDLE;
      reg_sum_d = '0;
      cnt_d     = '0;
      carry_d   = 1'b0;
      sum_d     = sum_q;
      ovf_d     = ovf_q;
      owner_d   = owner_q;
      last_d    = last_q;
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Reset) begin
      state_q   <= IDLE;
      reg_sum_q <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      owner_q   <= 1'b0;
      carry_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      reg_sum_q <= reg_sum_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      owner_q   <= owner_d;
      carry_q   <= carry_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Busy      = (state_q == ACCUM);
  assign Done      = (state_q == DONE);
  assign Req0Ready = Busy && !owner_q;
  assign Req1Ready = Busy &&  owner_q;
  assign RegSum    = reg_sum_q;
  assign Sum       = sum_q;
  assign Ovf       = ovf_q;
  assign Owner     = owner_q;

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched: hand-computed bursts, arbitration, stall, clear and reset.
module tb_accum_sched;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Req0Valid, Req1Valid, Clear;
  logic [3:0] Req0Data, Req1Data;
  logic       Req0Ready, Req1Ready;
  logic [3:0] RegSum, Sum;
  logic       Ovf, Owner, Busy, Done;

  int n_vec = 0;
  int n_err = 0;

  accum_sched #(.WIDTH(4), .BURST(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .Clear(Clear), .RegSum(RegSum), .Sum(Sum), .Ovf(Ovf),
    .Owner(Owner), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Req0Valid = 1'b0; Req1Valid = 1'b0; Clear = 1'b0;
    Req0Data  = 4'd0; Req1Data  = 4'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_regsum"}, RegSum, 0);
    check({tag, "_sum"},    Sum,    0);
    check({tag, "_ovf"},    Ovf,    0);
    check({tag, "_owner"},  Owner,  0);
    check({tag, "_busy"},   Busy,   0);
    check({tag, "_done"},   Done,   0);
    check({tag, "_rdy0"},   Req0Ready, 0);
    check({tag, "_rdy1"},   Req1Ready, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b0;
    step();
    check_reset_state("reset");
    Reset = 1'b1;
  endtask

  task automatic drive(input bit r, input bit v, input logic [3:0] d);
    if (r) begin Req1Valid = v; Req1Data = d; end
    else   begin Req0Valid = v; Req0Data = d; end
  endtask

  // One single-requester burst; beats come from d low nibble first.
  // stall_at >= 0 drops Valid for 3 cycles before that beat index.
  task automatic burst(input bit r, input logic [15:0] d, input int stall_at,
                       input logic [3:0] exp_sum, input bit exp_ovf);
    logic [3:0] acc;
    acc = 4'd0;
    drive(r, 1'b1, d[3:0]);
    step();
    check("grant_owner", Owner, r);
    check("grant_busy", Busy, 1);
    check("grant_regsum", RegSum, 0);
    check("grant_rdy_own", r ? Req1Ready : Req0Ready, 1);
    check("grant_rdy_other", r ? Req0Ready : Req1Ready, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        drive(r, 1'b0, 4'hF);
        repeat (3) begin
          step();
          check("stall_regsum", RegSum, acc);
          check("stall_busy", Busy, 1);
        end
      end
      drive(r, 1'b1, d[4*i +: 4]);
      step();
      acc = acc + d[4*i +: 4];
      check("beat_regsum", RegSum, acc);
    end
    drive(r, 1'b0, 4'd0);
    check("done_pulse", Done, 1);
    check("done_sum", Sum, exp_sum);
    check("done_ovf", Ovf, exp_ovf);
    check("done_owner", Owner, r);
    check("done_busy", Busy, 0);
    step();
    check("post_done", Done, 0);
    check("post_sum_hold", Sum, exp_sum);
  endtask

  logic       exp_own [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] exp_sum [3] = '{4'd4, 4'd12, 4'd4};
  logic       exp_ovf [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    idle_inputs();
    Reset = 1'b0;
    step();
    do_reset();

    // Requester 0 alone: 1+2+3+4 = 10.
    burst(1'b0, 16'h4321, -1, 4'd10, 1'b0);

    // Both valid continuously from reset: grants 0,1,0.
    do_reset();
    Req0Valid = 1'b1; Req0Data = 4'd5;
    Req1Valid = 1'b1; Req1Data = 4'd3;
    for (int b = 0; b < 3; b++) begin
      step();
      check("rr_owner", Owner, exp_own[b]);
      check("rr_busy", Busy, 1);
      repeat (4) step();
      check("rr_done", Done, 1);
      check("rr_sum", Sum, exp_sum[b]);
      check("rr_ovf", Ovf, exp_ovf[b]);
      step();
      check("rr_gap_busy", Busy, 0);
      check("rr_gap_done", Done, 0);
    end
    idle_inputs();

    // Requester 1: 8*4 wraps to 0 with carry, then 1*4 = 4 clears the carry.
    burst(1'b1, 16'h8888, -1, 4'd0, 1'b1);
    burst(1'b1, 16'h1111, -1, 4'd4, 1'b0);

    // Stall after beat 2.
    do_reset();
    burst(1'b0, 16'h4321, 2, 4'd10, 1'b0);

    // Clear after beat 2, with beat 3 offered in the same cycle.
    Req0Valid = 1'b1; Req0Data = 4'd1;
    step();
    check("clr_grant", Owner, 0);
    step();
    step();
    check("clr_beat2", RegSum, 2);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    Req0Valid = 1'b0;
    check("clr_regsum", RegSum, 0);
    check("clr_busy", Busy, 0);
    check("clr_done", Done, 0);
    check("clr_sum", Sum, 10);
    check("clr_ovf", Ovf, 0);
    step();
    check("clr_no_done", Done, 0);

    // Last served is still 0, so requester 1 wins; requester 0 data is ignored.
    Req0Valid = 1'b1; Req0Data = 4'd1;
    Req1Valid = 1'b1; Req1Data = 4'd2;
    step();
    check("rr_after_clr", Owner, 1);
    step();
    check("nonowner_b1", RegSum, 2);
    step();
    check("nonowner_b2", RegSum, 4);

    // Reset during beat 3 overrides Clear and the handshake.
    Reset = 1'b0;
    Clear = 1'b1;
    step();
    check_reset_state("midreset");
    Reset = 1'b1;
    Clear = 1'b0;
    step();
    check("reset_grant_owner", Owner, 0);
    check("reset_grant_busy", Busy, 1);
    idle_inputs();
    Clear = 1'b1;
    step();
    check("final_idle", Busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_sched.md
ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, data/accumulator width in bits.
REQ-002 SHALL provide parameter BURST, default 4, operands per granted burst (legal range 1..15).
REQ-003 SHALL provide port Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port Reset  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port Req0Valid  input  1  requester 0 presents an operand.
REQ-006 SHALL provide port Req0Data  input  WIDTH  requester 0 operand.
REQ-007 SHALL provide port Req0Ready  output  1  requester 0 operand accepted this cycle when Req0Valid also high.
REQ-008 SHALL provide ports Req1Valid, Req1Data and Req1Ready with the same directions and meanings as the requester 0 ports.
REQ-009 SHALL provide port Clear  input  1  abort current burst, return to IDLE.
REQ-010 SHALL provide port RegSum  output  WIDTH  running accumulator register.
REQ-011 SHALL provide port Sum  output  WIDTH  final burst result, held until the next burst completes.
REQ-012 SHALL provide port Ovf  output  1  sticky carry-out of the completed burst.
REQ-013 SHALL provide port Owner  output  1  requester currently or last granted.
REQ-014 SHALL provide port Busy  output  1  high while in ACCUM.
REQ-015 SHALL provide port Done  output  1  one-cycle pulse on burst completion.

Function
REQ-016 SHALL implement the states IDLE, ACCUM and DONE.
REQ-017 IDLE: if any ReqNValid is high, SHALL grant one requester, load Owner, clear RegSum, clear the beat counter and the internal carry flag, and go to ACCUM the next cycle.
REQ-018 Arbitration SHALL be round-robin: when both are valid, grant the requester not served by the last completed burst; after reset, requester 0 wins.
REQ-019 Single valid requester SHALL be granted regardless of the last served requester.
REQ-020 ReqNReady SHALL equal (state==ACCUM && Owner==N), decoded combinationally from registered state; the non-owner Ready SHALL be 0.
REQ-021 Beat accepted when Valid && Ready: RegSum <= (RegSum + Data) mod 2^WIDTH; internal carry flag |= carry-out; beat counter += 1.
REQ-022 Owner Valid low in ACCUM SHALL stall: RegSum and counter hold; no timeout.
REQ-023 On acceptance of beat BURST, SHALL go to DONE next cycle; Sum <= final RegSum value and Ovf <= carry flag on that same edge.
REQ-024 DONE SHALL last exactly one cycle with Done=1, record Owner as last served, then return to IDLE; no grant is made in DONE.
REQ-025 Minimum burst occupancy SHALL be BURST+2 cycles (grant, BURST beats, DONE); back-to-back bursts SHALL be separated by one IDLE cycle.
REQ-026 Clear high in any state SHALL force IDLE next cycle, RegSum <= 0, no Done pulse; Sum, Ovf and the last-served record are unchanged.
REQ-027 Clear SHALL take priority over a beat accepted in the same cycle; that beat is not accumulated, although Ready was high.
REQ-028 Data from a non-owner SHALL never affect RegSum.

Reset
REQ-029 Reset low at a rising edge SHALL set state=IDLE, RegSum=0, Sum=0, Ovf=0, Owner=0, Busy=0, Done=0, beat counter=0, last served=1 (so requester 0 wins first), from any state including mid-burst.
REQ-030 Reset SHALL take priority over Clear and all handshakes.

Verification
REQ-031 Req0 only, data 1,2,3,4, BURST=4 -> Req0Ready 4 beats, Done pulse, Sum=10, Ovf=0, Owner=0.
REQ-032 Both valid continuously, Req0 data 5s, Req1 data 3s -> grants alternate 0,1,0; Sum alternates 4 (20 mod 16, Ovf=1) and 12 (Ovf=0).
REQ-033 Req1 burst 8,8,8,8 -> Sum=0, Ovf=1; following burst 1,1,1,1 -> Sum=4, Ovf=0.
REQ-034 Owner Valid dropped 3 cycles after beat 2 -> RegSum holds, Done arrives 3 cycles later, Sum still correct.
REQ-035 Clear after beat 2 of burst 1,1,1,1 following prior Sum=10 -> IDLE, RegSum=0, no Done, Sum=10.
REQ-036 Reset low during beat 3 -> all outputs at REQ-029 values the next cycle; with both valid, the next grant goes to requester 0.
